wide_add_seq: RTL and testbench

- Multi-cycle controller that sequences the team's existing 8-bit `hybrid_adder` to add two NBYTES-byte operands, one byte per cycle, least-significant byte first.
- Carry is chained between bytes.
- Sits between a requester (start/done handshake) and a single shared 8-bit adder instance, which stays outside this block.

---
 rtl/wide_add_pkg.sv | 27 ++
 rtl/wide_add_seq.sv | 136 +++++++++++++
 tb/tb_wide_add_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/wide_add_pkg.sv
// wide_add_pkg
// Shared definitions for the byte-serial wide adder controller.
//   BYTE_W  : width of one slice handled by the shared adder
//   state_e : controller state encoding (ST_IDLE / ST_RUN / ST_DONE)
//   clog2   : elaboration-time ceil(log2(n)), used for the byte index width
package wide_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wide_add_seq.sv
// wide_add_seq
// Byte-serial controller that drives one shared external 8-bit adder to add
// two NBYTES-byte operands, least-significant byte first, chaining the carry.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start                request, only sampled while idle
//   op_a, op_b, cin      operands and carry-in, latched on an accepted start
//   busy, done           busy while not idle; done pulses for one cycle
//   result, cout         sum and carry-out, held until the next accepted start
//   add_a, add_b,        to the shared adder (zero when not in RUN)
//   add_cin
//   add_sum, add_cout    from the shared adder (combinational)
//   sub                  only with WIDE_ADD_SEQ_SUB_EN defined: subtract
//                        op_b from op_a; cout=1 then means no borrow
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start, adder inputs parked at 0
// ST_RUN  | adding byte idx, writing result byte idx and the carry
// ST_DONE | one-cycle done pulse, result/cout valid
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [BYTE_W*NBYTES-1:0] op_a,
    input  logic [BYTE_W*NBYTES-1:0] op_b,
    input  logic                     cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
    input  logic                     sub,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [BYTE_W*NBYTES-1:0] result,
    output logic                     cout,
    output logic [BYTE_W-1:0]        add_a,
    output logic [BYTE_W-1:0]        add_b,
    output logic                     add_cin,
    input  logic [BYTE_W-1:0]        add_sum,
    input  logic                     add_cout
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = clog2(NBYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q, cout_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    carry_d  = cin;
`ifdef WIDE_ADD_SEQ_SUB_EN
                    // Two's-complement subtract: A + ~B + 1.
                    if (sub) begin
                        b_d     = ~op_b;
                        carry_d = 1'b1;
                    end
`endif
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                add_a   = a_q[idx_q*BYTE_W +: BYTE_W];
                add_b   = b_q[idx_q*BYTE_W +: BYTE_W];
                add_cin = carry_q;
                result_d[idx_q*BYTE_W +: BYTE_W] = add_sum;
                carry_d = add_cout;
                if (idx_q == IDX_LAST) begin
                    cout_d  = add_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq
// Directed bench for wide_add_seq with NBYTES=4. The shared 8-bit adder is
// modelled here as a plain combinational sum. Build with WIDE_ADD_SEQ_SUB_EN
// defined to also exercise subtraction.
module tb_wide_add_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        cout;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;

    int checks;
    int failures;

    wide_add_seq #(.NBYTES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
`ifdef WIDE_ADD_SEQ_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Shared 8-bit adder model.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and follows it to completion. Returns the number of
    // edges from the accepting edge until done is seen, and the add_cin value
    // observed in each RUN cycle (bit k = RUN cycle k after acceptance).
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s,
                          input logic [31:0] exp_res, input logic exp_cout,
                          output int lat, output logic [31:0] cin_hist);
        op_a  = a;
        op_b  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a  = 32'hDEAD_BEEF;
        op_b  = 32'hCAFE_F00D;
        cin   = 1'b1;
        check({tag, ".clr"}, result, 32'h0);
        check({tag, ".busy"}, 32'(busy), 32'd1);
        check({tag, ".add_a0"}, 32'(add_a), 32'(a[7:0]));
        lat      = 0;
        cin_hist = '0;
        while (!done && lat < 20) begin
            cin_hist[lat] = add_cin;
            tick();
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'd4);
        check({tag, ".res"}, result, exp_res);
        check({tag, ".cout"}, 32'(cout), 32'(exp_cout));
        tick();
        check({tag, ".done_1cyc"}, 32'({busy, done}), 32'd0);
        check({tag, ".hold"}, result, exp_res);
    endtask

    int          lat;
    logic [31:0] hist;
    int          npulse;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op_a     = '0;
        op_b     = '0;
        cin      = 1'b0;
        sub      = 1'b0;
        tick();
        tick();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.result", result, 32'h0);
        check("rst.cout", 32'(cout), 32'd0);
        check("rst.add", 32'({add_a, add_b, add_cin}), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("basic", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, lat, hist);
        check("idle.add", 32'({add_a, add_b, add_cin}), 32'd0);

        run_op("carry01", 32'h0000_00AD, 32'h0000_00D6, 1'b0, 1'b0, 32'h0000_0183, 1'b0, lat, hist);

        run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, lat, hist);
        check("ripple.add_cin", hist, 32'h0000_000E);

        run_op("cin_top", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1, lat, hist);
        check("cin_top.add_cin", hist, 32'h0000_0001);

        // Start re-asserted with different operands while busy is ignored.
        op_a  = 32'h0000_0001;
        op_b  = 32'h0000_0001;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        op_a   = 32'hFFFF_FFFF;
        op_b   = 32'hFFFF_FFFF;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) start = 1'b0;
            if (done) begin
                npulse++;
                check("ignore.res", result, 32'h0000_0002);
            end
            tick();
        end
        check("ignore.pulses", 32'(npulse), 32'd1);
        check("ignore.idle", 32'(busy), 32'd0);

        // Reset in the second RUN cycle discards the partial result.
        op_a  = 32'hFFFF_FFFF;
        op_b  = 32'hFFFF_FFFF;
        cin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rst_mid.partial", result, 32'h0000_00FF);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid.busy", 32'(busy), 32'd0);
        check("rst_mid.done", 32'(done), 32'd0);
        check("rst_mid.result", result, 32'h0);
        check("rst_mid.cout", 32'(cout), 32'd0);
        tick();
        check("rst_mid.stay", 32'(busy), 32'd0);

        run_op("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, lat, hist);

        // Back-to-back: accepted right in the first idle cycle after DONE.
        run_op("b2b", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, lat, hist);

`ifdef WIDE_ADD_SEQ_SUB_EN
        run_op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, lat, hist);
        run_op("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, lat, hist);
        run_op("sub_off", 32'd7, 32'd5, 1'b1, 1'b0, 32'h0000_000D, 1'b0, lat, hist);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
